mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-cycle memory port between an instruction-fetch requester
// (i_*) and a load/store requester (d_*). A request is accepted in the cycle
// it is granted, and the memory access happens in that cycle. Each requester
// has its own registered response slot, which holds until it is drained.
// Misaligned accesses are accepted but cause no memory write. They respond
// with err=1 and data 0.
//
// Configuration:
//   MEM_ARB_RR_EN  defined   -> round-robin between the two ports on contention
//                  undefined -> the data port has fixed priority over fetch
//
// Parameters:
//   ADDR_W            byte-address width of every address port
//
// Ports:
//   clk, rst_n        rising-edge clock, synchronous active-low reset
//   i_req_valid/addr/ready            fetch request (word read)
//   i_rsp_valid/data/err/ready        fetch response slot
//   d_req_valid/addr/we/size/unsigned/wdata/ready   data request
//   d_rsp_valid/data/err/ready        data response slot
//   mem_address, mem_write_data, mem_byte_enable, mem_write_enable   to memory
//   mem_read_data     combinational read data for mem_address
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              i_req_valid,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              i_req_ready,
  output logic              i_rsp_valid,
  output logic [31:0]       i_rsp_data,
  output logic              i_rsp_err,
  input  logic              i_rsp_ready,

  input  logic              d_req_valid,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic              d_req_we,
  input  logic [1:0]        d_req_size,
  input  logic              d_req_unsigned,
  input  logic [31:0]       d_req_wdata,
  output logic              d_req_ready,
  output logic              d_rsp_valid,
  output logic [31:0]       d_rsp_data,
  output logic              d_rsp_err,
  input  logic              d_rsp_ready,

  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_write_data,
  output logic [3:0]        mem_byte_enable,
  output logic              mem_write_enable,
  input  logic [31:0]       mem_read_data
);

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_BAD  = 2'b11
  } size_e;

  size_e       d_size;
  logic        i_elig;
  logic        d_elig;
  logic        grant_i;
  logic        grant_d;
  logic        i_misalign;
  logic        d_err;
  logic [3:0]  d_mask;
  logic [31:0] d_store_data;
  logic [31:0] d_lane;
  logic [31:0] d_load_data;

  assign d_size = size_e'(d_req_size);

  // A requester may only win when its response slot is empty or is being
  // drained this very cycle, so an accepted response never overwrites one
  // the consumer has not taken yet.
  assign i_elig = i_req_valid && (!i_rsp_valid || i_rsp_ready);
  assign d_elig = d_req_valid && (!d_rsp_valid || d_rsp_ready);

`ifdef MEM_ARB_RR_EN
  // 1 = last accepted request came from the data port. The cleared value
  // (fetch) makes the data port win the first contention after reset.
  logic last_d;

  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (rst_n) begin
      if (d_elig && i_elig) begin
        grant_d = !last_d;
        grant_i = last_d;
      end else begin
        grant_d = d_elig;
        grant_i = i_elig;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_d <= 1'b0;
    end else if (grant_i || grant_d) begin
      last_d <= grant_d;
    end
  end
`else
  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (rst_n) begin
      grant_d = d_elig;
      grant_i = i_elig && !d_elig;
    end
  end
`endif

  assign i_req_ready = grant_i;
  assign d_req_ready = grant_d;

  assign i_misalign = (i_req_addr[1:0] != 2'b00);

  // Alignment check, lane mask and store replication for the data port.
  // NOTE: every variable written in an always_comb gets a default first;
  // without it a path that skips the assignment would infer a latch.
  always_comb begin
    d_err        = 1'b0;
    d_mask       = 4'b1111;
    d_store_data = d_req_wdata;
    unique case (d_size)
      SZ_BYTE: begin
        d_mask       = 4'b0001 << d_req_addr[1:0];
        d_store_data = {4{d_req_wdata[7:0]}};
      end
      SZ_HALF: begin
        d_err        = d_req_addr[0];
        d_mask       = 4'b0011 << d_req_addr[1:0];
        d_store_data = {2{d_req_wdata[15:0]}};
      end
      SZ_WORD: d_err = (d_req_addr[1:0] != 2'b00);
      SZ_BAD:  d_err = 1'b1;
    endcase
  end

  // Shift the addressed lane down to bit 0, then extend to 32 bits.
  assign d_lane = mem_read_data >> {d_req_addr[1:0], 3'b000};

  always_comb begin
    d_load_data = mem_read_data;
    unique case (d_size)
      SZ_BYTE: d_load_data = {{24{!d_req_unsigned && d_lane[7]}},  d_lane[7:0]};
      SZ_HALF: d_load_data = {{16{!d_req_unsigned && d_lane[15]}}, d_lane[15:0]};
      default: d_load_data = mem_read_data;
    endcase
  end

  // Memory-side drive. The bus is idle (no enables, no write) unless a
  // well-formed request is granted.
  always_comb begin
    mem_address      = '0;
    mem_write_data   = '0;
    mem_byte_enable  = 4'b0000;
    mem_write_enable = 1'b0;
    if (grant_i && !i_misalign) begin
      mem_address     = {i_req_addr[ADDR_W-1:2], 2'b00};
      mem_byte_enable = 4'b1111;
    end else if (grant_d && !d_err) begin
      mem_address     = {d_req_addr[ADDR_W-1:2], 2'b00};
      mem_byte_enable = d_mask;
      if (d_req_we) begin
        mem_write_enable = 1'b1;
        mem_write_data   = d_store_data;
      end
    end
  end

  // Response slots: a grant loads the slot, and the slot holds until it is
  // drained. Reset discards any pending response.
  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      i_rsp_valid <= 1'b0;
      i_rsp_data  <= '0;
      i_rsp_err   <= 1'b0;
    end else if (grant_i) begin
      i_rsp_valid <= 1'b1;
      i_rsp_data  <= i_misalign ? 32'h0 : mem_read_data;
      i_rsp_err   <= i_misalign;
    end else if (i_rsp_ready) begin
      i_rsp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d_rsp_valid <= 1'b0;
      d_rsp_data  <= '0;
      d_rsp_err   <= 1'b0;
    end else if (grant_d) begin
      d_rsp_valid <= 1'b1;
      d_rsp_data  <= (d_err || d_req_we) ? 32'h0 : d_load_data;
      d_rsp_err   <= d_err;
    end else if (d_rsp_ready) begin
      d_rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter with a small byte-enabled memory model
// (64 words, combinational read). Expected grant order follows MEM_ARB_RR_EN.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_req_valid;
  logic [ADDR_W-1:0] i_req_addr;
  logic              i_req_ready;
  logic              i_rsp_valid;
  logic [31:0]       i_rsp_data;
  logic              i_rsp_err;
  logic              i_rsp_ready;
  logic              d_req_valid;
  logic [ADDR_W-1:0] d_req_addr;
  logic              d_req_we;
  logic [1:0]        d_req_size;
  logic              d_req_unsigned;
  logic [31:0]       d_req_wdata;
  logic              d_req_ready;
  logic              d_rsp_valid;
  logic [31:0]       d_rsp_data;
  logic              d_rsp_err;
  logic              d_rsp_ready;
  logic [ADDR_W-1:0] mem_address;
  logic [31:0]       mem_write_data;
  logic [3:0]        mem_byte_enable;
  logic              mem_write_enable;
  logic [31:0]       mem_read_data;

  int checks   = 0;
  int failures = 0;
  int reset_writes = 0;

  logic [31:0] mem [0:63] = '{4: 32'h00500093, 8: 32'h11223344, default: 32'h0};

  always #5 clk = ~clk;

  assign mem_read_data = mem[mem_address[7:2]];

  always @(posedge clk) begin
    if (mem_write_enable) begin
      if (!rst_n) reset_writes++;
      for (int b = 0; b < 4; b++)
        if (mem_byte_enable[b])
          mem[mem_address[7:2]][8*b +: 8] <= mem_write_data[8*b +: 8];
    end
  end

  mem_port_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_req_ready),
    .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data), .i_rsp_err(i_rsp_err),
    .i_rsp_ready(i_rsp_ready),
    .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_we(d_req_we),
    .d_req_size(d_req_size), .d_req_unsigned(d_req_unsigned),
    .d_req_wdata(d_req_wdata), .d_req_ready(d_req_ready),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data), .d_rsp_err(d_rsp_err),
    .d_rsp_ready(d_rsp_ready),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_byte_enable(mem_byte_enable), .mem_write_enable(mem_write_enable),
    .mem_read_data(mem_read_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    i_req_valid    = 1'b0;
    i_req_addr     = '0;
    d_req_valid    = 1'b0;
    d_req_addr     = '0;
    d_req_we       = 1'b0;
    d_req_size     = 2'b10;
    d_req_unsigned = 1'b0;
    d_req_wdata    = '0;
  endtask

  task automatic d_drive(input logic [31:0] addr, input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] wdata);
    d_req_valid    = 1'b1;
    d_req_addr     = addr;
    d_req_we       = we;
    d_req_size     = size;
    d_req_unsigned = uns;
    d_req_wdata    = wdata;
  endtask

  logic [0:3] exp_d;

  initial begin
`ifdef MEM_ARB_RR_EN
    exp_d = 4'b1010;
`else
    exp_d = 4'b1111;
`endif
    // Reset with both requesters active: nothing may be accepted or written.
    rst_n       = 1'b0;
    i_rsp_ready = 1'b1;
    d_rsp_ready = 1'b1;
    clear_reqs();
    i_req_valid = 1'b1;
    i_req_addr  = 32'h10;
    d_drive(32'h20, 1'b1, 2'b10, 1'b0, 32'hFFFFFFFF);
    #2;
    check("rst_i_ready", i_req_ready, 1'b0);
    check("rst_d_ready", d_req_ready, 1'b0);
    check("rst_we", mem_write_enable, 1'b0);
    tick();
    tick();
    check("rst_i_rsp_valid", i_rsp_valid, 1'b0);
    check("rst_d_rsp_valid", d_rsp_valid, 1'b0);
    check("rst_d_rsp_data", d_rsp_data, 32'h0);
    check("rst_no_write", mem[8], 32'h11223344);
    clear_reqs();
    rst_n = 1'b1;
    #1;
    check("idle_be", mem_byte_enable, 4'b0000);
    check("idle_we", mem_write_enable, 1'b0);

    // Fetch from 0x10.
    i_req_valid = 1'b1;
    i_req_addr  = 32'h10;
    #1;
    check("fetch_ready", i_req_ready, 1'b1);
    check("fetch_addr", mem_address, 32'h10);
    check("fetch_we", mem_write_enable, 1'b0);
    tick();
    clear_reqs();
    check("fetch_rsp_valid", i_rsp_valid, 1'b1);
    check("fetch_rsp_data", i_rsp_data, 32'h00500093);
    check("fetch_rsp_err", i_rsp_err, 1'b0);
    tick();
    check("fetch_drained", i_rsp_valid, 1'b0);

    // Store byte 0xAB at 0x23.
    d_drive(32'h23, 1'b1, 2'b00, 1'b0, 32'h000000AB);
    #1;
    check("sb_ready", d_req_ready, 1'b1);
    check("sb_be", mem_byte_enable, 4'b1000);
    check("sb_wdata", mem_write_data, 32'hABABABAB);
    check("sb_addr", mem_address, 32'h20);
    check("sb_we", mem_write_enable, 1'b1);
    tick();
    clear_reqs();
    check("sb_rsp_valid", d_rsp_valid, 1'b1);
    check("sb_rsp_data", d_rsp_data, 32'h0);
    check("sb_rsp_err", d_rsp_err, 1'b0);
    check("sb_mem", mem[8], 32'hAB223344);

    // Loads back from the same word.
    d_drive(32'h23, 1'b0, 2'b00, 1'b0, 32'h0);
    #1;
    check("lb_ready", d_req_ready, 1'b1);
    check("lb_we", mem_write_enable, 1'b0);
    tick();
    check("lb_signed", d_rsp_data, 32'hFFFFFFAB);
    d_drive(32'h23, 1'b0, 2'b00, 1'b1, 32'h0);
    tick();
    check("lbu", d_rsp_data, 32'h000000AB);
    d_drive(32'h22, 1'b0, 2'b01, 1'b0, 32'h0);
    tick();
    check("lh_signed", d_rsp_data, 32'hFFFFAB22);
    d_drive(32'h20, 1'b0, 2'b01, 1'b1, 32'h0);
    tick();
    check("lhu_low", d_rsp_data, 32'h00003344);
    check("lhu_err", d_rsp_err, 1'b0);

    // Misaligned half store: accepted, no write, error response.
    d_drive(32'h21, 1'b1, 2'b01, 1'b0, 32'h00005555);
    #1;
    check("sh_mis_ready", d_req_ready, 1'b1);
    check("sh_mis_we", mem_write_enable, 1'b0);
    tick();
    clear_reqs();
    check("sh_mis_err", d_rsp_err, 1'b1);
    check("sh_mis_data", d_rsp_data, 32'h0);
    check("sh_mis_mem", mem[8], 32'hAB223344);

    // Illegal size code.
    d_drive(32'h20, 1'b0, 2'b11, 1'b0, 32'h0);
    tick();
    clear_reqs();
    check("size11_err", d_rsp_err, 1'b1);

    // Misaligned fetch.
    i_req_valid = 1'b1;
    i_req_addr  = 32'h12;
    #1;
    check("fetch_mis_be", mem_byte_enable, 4'b0000);
    tick();
    clear_reqs();
    check("fetch_mis_err", i_rsp_err, 1'b1);
    check("fetch_mis_data", i_rsp_data, 32'h0);

    // Data response back-pressure; fetch keeps flowing.
    d_rsp_ready = 1'b0;
    d_drive(32'h10, 1'b0, 2'b10, 1'b0, 32'h0);
    tick();
    check("bp_first_valid", d_rsp_valid, 1'b1);
    check("bp_first_data", d_rsp_data, 32'h00500093);
    d_drive(32'h20, 1'b0, 2'b10, 1'b0, 32'h0);
    i_req_valid = 1'b1;
    i_req_addr  = 32'h10;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("bp_d_ready_%0d", k), d_req_ready, 1'b0);
      check($sformatf("bp_i_ready_%0d", k), i_req_ready, 1'b1);
      tick();
      check($sformatf("bp_d_data_%0d", k), d_rsp_data, 32'h00500093);
      check($sformatf("bp_i_data_%0d", k), i_rsp_data, 32'h00500093);
    end
    d_rsp_ready = 1'b1;
    #1;
    check("bp_release_d_ready", d_req_ready, 1'b1);
    tick();
    clear_reqs();
    check("bp_release_data", d_rsp_data, 32'hAB223344);

    // Reset while a data response is pending, with a store presented.
    d_rsp_ready = 1'b0;
    check("pre_rst_d_valid", d_rsp_valid, 1'b1);
    rst_n = 1'b0;
    d_drive(32'h20, 1'b1, 2'b10, 1'b0, 32'hDEADBEEF);
    #1;
    check("rst2_we", mem_write_enable, 1'b0);
    tick();
    check("rst2_d_valid", d_rsp_valid, 1'b0);
    check("rst2_i_valid", i_rsp_valid, 1'b0);
    check("rst2_mem", mem[8], 32'hAB223344);
    check("rst2_writes", reset_writes, 32'd0);
    clear_reqs();
    d_rsp_ready = 1'b1;
    rst_n = 1'b1;

    // Contention straight after reset.
    d_drive(32'h20, 1'b0, 2'b10, 1'b0, 32'h0);
    i_req_valid = 1'b1;
    i_req_addr  = 32'h10;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("arb_d_%0d", k), d_req_ready, exp_d[k]);
      check($sformatf("arb_i_%0d", k), i_req_ready, !exp_d[k]);
      tick();
    end
    clear_reqs();
    tick();

    // Both slots full: nobody is eligible.
    i_rsp_ready = 1'b0;
    d_rsp_ready = 1'b0;
    i_req_valid = 1'b1;
    i_req_addr  = 32'h10;
    tick();
    clear_reqs();
    d_drive(32'h10, 1'b0, 2'b10, 1'b0, 32'h0);
    tick();
    i_req_valid = 1'b1;
    i_req_addr  = 32'h10;
    #1;
    check("full_i_valid", i_rsp_valid, 1'b1);
    check("full_d_valid", d_rsp_valid, 1'b1);
    check("full_i_ready", i_req_ready, 1'b0);
    check("full_d_ready", d_req_ready, 1'b0);
    check("full_we", mem_write_enable, 1'b0);
    clear_reqs();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
